// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle for the iterative shift sequencer.
// The master drives commands and OutReady, and the slave returns results.
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
);
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] Hyrja;
   logic [SHW-1:0]   Shamt;
   logic [1:0]       Funct;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] Result;
   logic             Busy;

   modport master (
      output InValid, Hyrja, Shamt, Funct, OutReady,
      input  InReady, OutValid, Result, Busy
   );

   modport slave (
      input  InValid, Hyrja, Shamt, Funct, OutReady,
      output InReady, OutValid, Result, Busy
   );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative shifter that moves up to STEP bits per cycle.
// It supports SLL, SRL, SRA and ROR, with valid/ready handshakes on the command and the result.
//
// state | meaning
// IDLE  | waiting for a command, InReady=1
// SHIFT | shifting the data register, Busy=1, commands ignored
// HOLD  | result presented (OutValid=1) until OutReady
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4,
   parameter int STEP  = 1
) (
   input logic             Clock,
   input logic             Reset,
   shift_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

   state_t           state, state_nx;
   logic [WIDTH-1:0] data, data_nx;
   logic [SHW-1:0]   cnt, cnt_nx;
   logic [1:0]       funct, funct_nx;
   logic [SHW:0]     n;
   logic [WIDTH-1:0] shifted;
   logic             accept;

   assign bus.InReady  = (state == IDLE) || ((state == HOLD) && bus.OutReady);
   assign bus.OutValid = (state == HOLD);
   assign bus.Busy     = (state == SHIFT);
   assign bus.Result   = data;
   assign accept       = bus.InValid && bus.InReady;

   // The last step may be shorter than STEP when the count is not a multiple of STEP.
   always_comb begin
      n = ({1'b0, cnt} < STEP_W) ? {1'b0, cnt} : STEP_W;
      case (funct)
         2'b00:   shifted = data << n;
         2'b01:   shifted = data >> n;
         2'b10:   shifted = $unsigned($signed(data) >>> n);
         default: shifted = (data >> n) | (data << (WIDTH - int'(n)));
      endcase
   end

   always_comb begin
      state_nx = state;
      data_nx  = data;
      cnt_nx   = cnt;
      funct_nx = funct;
      case (state)
         SHIFT: begin
            data_nx = shifted;
            cnt_nx  = cnt - n[SHW-1:0];
            if (cnt_nx == '0) state_nx = HOLD;
         end
         IDLE, HOLD: begin
            if (accept) begin
               data_nx  = bus.Hyrja;
               cnt_nx   = bus.Shamt;
               funct_nx = bus.Funct;
               state_nx = (bus.Shamt != '0) ? SHIFT : HOLD;
            end else if ((state == HOLD) && bus.OutReady) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         data  <= '0;
         cnt   <= '0;
         funct <= '0;
      end else begin
         state <= state_nx;
         data  <= data_nx;
         cnt   <= cnt_nx;
         funct <= funct_nx;
      end
   end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with STEP=1 and STEP=4 instances.
// Table vectors, hand-written corner sequences and random ops are checked against a one-shot shift model.
module tb_shift_sequencer;
   logic Clock;
   logic rst1, rst4;
   int   checks   = 0;
   int   failures = 0;

   shift_sequencer_if #(.WIDTH(16), .SHW(4)) if1 ();
   shift_sequencer_if #(.WIDTH(16), .SHW(4)) if4 ();

   shift_sequencer #(.WIDTH(16), .SHW(4), .STEP(1)) u1 (.Clock(Clock), .Reset(rst1), .bus(if1));
   shift_sequencer #(.WIDTH(16), .SHW(4), .STEP(4)) u4 (.Clock(Clock), .Reset(rst4), .bus(if4));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      int          sel;
      logic [15:0] h;
      logic [3:0]  s;
      logic [1:0]  f;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [15:0] ref_shift(input logic [15:0] h, input logic [3:0] s,
                                             input logic [1:0] f);
      logic [31:0] d;
      case (f)
         2'b00:   return h << s;
         2'b01:   return h >> s;
         2'b10:   return 16'($signed(h) >>> s);
         default: begin
            d = {h, h} >> s;
            return d[15:0];
         end
      endcase
   endfunction

   function automatic logic ov(input int sel);
      return (sel == 4) ? if4.OutValid : if1.OutValid;
   endfunction
   function automatic logic ir(input int sel);
      return (sel == 4) ? if4.InReady : if1.InReady;
   endfunction
   function automatic logic bsy(input int sel);
      return (sel == 4) ? if4.Busy : if1.Busy;
   endfunction
   function automatic logic [15:0] res(input int sel);
      return (sel == 4) ? if4.Result : if1.Result;
   endfunction

   task automatic drv(input int sel, input logic v, input logic [15:0] h, input logic [3:0] s,
                      input logic [1:0] f, input logic ordy);
      if (sel == 4) begin
         if4.InValid = v; if4.Hyrja = h; if4.Shamt = s; if4.Funct = f; if4.OutReady = ordy;
      end else begin
         if1.InValid = v; if1.Hyrja = h; if1.Shamt = s; if1.Funct = f; if1.OutReady = ordy;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Call this at a negedge with the DUT in IDLE. It issues one command, scrambles the inputs
   // while the shift runs, and then consumes the result.
   task automatic run_op(input int sel, input logic [15:0] h, input logic [3:0] s,
                         input logic [1:0] f, input logic [15:0] exp, input string name);
      int edges, busy, need;
      need = (int'(s) + sel - 1) / sel;
      chk({name, "_inready"}, 32'(ir(sel)), 32'd1);
      drv(sel, 1'b1, h, s, f, 1'b1);
      cyc();
      edges = 1;
      busy  = 0;
      drv(sel, 1'b0, 16'($urandom), 4'($urandom), 2'($urandom), 1'b1);
      while (!ov(sel) && edges < 64) begin
         if (bsy(sel)) busy++;
         drv(sel, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 2'($urandom), 1'b1);
         cyc();
         edges++;
      end
      drv(sel, 1'b0, 16'($urandom), 4'($urandom), 2'($urandom), 1'b1);
      chk({name, "_latency"}, 32'(edges), 32'(need + 1));
      chk({name, "_busy"}, 32'(busy), 32'(need));
      chk({name, "_result"}, 32'(res(sel)), 32'(exp));
      cyc();
      chk({name, "_consumed"}, 32'(ov(sel)), 32'd0);
      chk({name, "_idle"}, 32'(ir(sel)), 32'd1);
   endtask

   initial begin
      int          seen;
      logic [15:0] h;
      logic [3:0]  s;
      logic [1:0]  f;

      vecs[0] = '{1, 16'h0001, 4'd2,  2'b00, 16'h0004, "sll2_s1"};
      vecs[1] = '{1, 16'h0400, 4'd6,  2'b01, 16'h0010, "srl6_s1"};
      vecs[2] = '{4, 16'h0400, 4'd6,  2'b01, 16'h0010, "srl6_s4"};
      vecs[3] = '{1, 16'h8000, 4'd15, 2'b10, 16'hFFFF, "sra15_s1"};
      vecs[4] = '{1, 16'h0001, 4'd1,  2'b11, 16'h8000, "ror1_s1"};
      vecs[5] = '{1, 16'hA5A5, 4'd0,  2'b00, 16'hA5A5, "zero_s1"};
      vecs[6] = '{4, 16'h8000, 4'd15, 2'b10, 16'hFFFF, "sra15_s4"};
      vecs[7] = '{4, 16'h1234, 4'd5,  2'b11, 16'hA091, "ror5_s4"};
      vecs[8] = '{4, 16'h00FF, 4'd3,  2'b00, 16'h07F8, "sll3_s4"};

      rst1 = 1'b1;
      rst4 = 1'b1;
      drv(1, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      drv(4, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      repeat (3) cyc();
      rst1 = 1'b0;
      rst4 = 1'b0;
      cyc();
      chk("rst_outvalid", 32'(if1.OutValid), 32'd0);
      chk("rst_busy", 32'(if1.Busy), 32'd0);
      chk("rst_result", 32'(if1.Result), 32'd0);
      chk("rst_inready", 32'(if1.InReady), 32'd1);
      chk("rst_inready4", 32'(if4.InReady), 32'd1);

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].sel, vecs[i].h, vecs[i].s, vecs[i].f, vecs[i].exp, vecs[i].name);

      // Backpressure: the result must be held while a new command waits.
      drv(1, 1'b1, 16'h1234, 4'd4, 2'b00, 1'b0);
      cyc();
      drv(1, 1'b0, 16'h0, 4'd0, 2'b00, 1'b0);
      seen = 0;
      while (!if1.OutValid && seen < 64) begin
         cyc();
         seen++;
      end
      chk("bp_reach_hold", 32'(if1.OutValid), 32'd1);
      drv(1, 1'b1, 16'h00F0, 4'd4, 2'b01, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_outvalid", 32'(if1.OutValid), 32'd1);
         chk("bp_result", 32'(if1.Result), 32'h2340);
         chk("bp_inready", 32'(if1.InReady), 32'd0);
      end
      if1.OutReady = 1'b1;
      #1;
      chk("bp_release_inready", 32'(if1.InReady), 32'd1);
      @(negedge Clock);
      cyc();
      drv(1, 1'b0, 16'hFFFF, 4'd0, 2'b00, 1'b1);
      chk("bp_new_busy", 32'(if1.Busy), 32'd1);
      chk("bp_new_outvalid", 32'(if1.OutValid), 32'd0);
      seen = 0;
      while (!if1.OutValid && seen < 64) begin
         cyc();
         seen++;
      end
      chk("bp_new_result", 32'(if1.Result), 32'h000F);
      chk("bp_new_latency", 32'(seen), 32'd3);
      cyc();

      // Reset three edges into a 10-bit shift.
      drv(1, 1'b1, 16'hFFFF, 4'd10, 2'b01, 1'b1);
      cyc();
      drv(1, 1'b0, 16'h0, 4'd0, 2'b00, 1'b1);
      repeat (3) cyc();
      chk("rs_busy_before", 32'(if1.Busy), 32'd1);
      rst1 = 1'b1;
      cyc();
      rst1 = 1'b0;
      chk("rs_outvalid", 32'(if1.OutValid), 32'd0);
      chk("rs_result", 32'(if1.Result), 32'd0);
      chk("rs_inready", 32'(if1.InReady), 32'd1);
      chk("rs_busy", 32'(if1.Busy), 32'd0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (if1.OutValid) seen++;
      end
      chk("rs_no_spurious", 32'(seen), 32'd0);

      for (int k = 0; k < 150; k++) begin
         h = 16'($urandom);
         s = 4'($urandom);
         f = 2'($urandom);
         run_op(1, h, s, f, ref_shift(h, s, f), "rand_s1");
      end
      for (int k = 0; k < 60; k++) begin
         h = 16'($urandom);
         s = 4'($urandom);
         f = 2'($urandom);
         run_op(4, h, s, f, ref_shift(h, s, f), "rand_s4");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
